input_debounce_edge: RTL and testbench

- Conditions the single-bit registered output of the upstream D flip-flop stage (its q) before downstream control logic uses it.
- Synchronises the input, debounces it with a stability counter FSM, and produces a clean level plus one-cycle rise and fall pulses.
- Keeps a wrapping count of debounced rising edges for bench and status use.

---
 rtl/debounce_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/input_debounce_edge.sv | 139 +++++++++++++
 tb/tb_input_debounce_edge.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debounce_pkg
// Purpose  : Shared state encoding and default constants for input debounce
//            stages.
// Revision : 1.0 - initial release
// ============================================================================
package debounce_pkg;

  // Debounce FSM: two settled states plus one qualifying state per direction.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } deb_state_t;

  localparam int DEB_STABLE_CYCLES = 4;
  localparam int DEB_CNT_W         = 8;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchroniser for a single-bit input, synchronous
//            active-high reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // Shift the raw bit through two stages; only the second stage is used.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/input_debounce_edge.sv
`default_nettype none
// ============================================================================
// Module   : input_debounce_edge
// Purpose  : Synchronises and debounces a single-bit input, producing a clean
//            level, one-cycle rise/fall pulses and a wrapping rise counter.
// Revision : 1.0 - initial release
// ============================================================================
module input_debounce_edge
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEB_STABLE_CYCLES,
  parameter int CNT_W         = DEB_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_in,
  input  logic             count_clr,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] event_count
);

  localparam int             STAB_W     = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] c_stab_one  = STAB_W'(1);
  localparam logic [STAB_W-1:0] c_stab_last = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);

  logic              sync_q;
  deb_state_t        state_q,    state_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              level_q,    level_d;
  logic              rise_q,     rise_d;
  logic              fall_q,     fall_d;
  logic [CNT_W-1:0]  count_q,    count_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (d_in),
    .q     (sync_q)
  );

  // Next-state logic. The synchronised bit is tested against explicit 1 and 0
  // so an unknown sample holds the current state instead of being taken as 0.
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    level_d    = level_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;

    case (state_q)
      IDLE_LOW: begin
        if (sync_q == 1'b1) begin
          state_d    = WAIT_HIGH;
          stab_cnt_d = c_stab_one;
        end
      end
      WAIT_HIGH: begin
        if (sync_q == 1'b0) begin
          // Glitch: drop back without touching level or pulses.
          state_d    = IDLE_LOW;
          stab_cnt_d = '0;
        end else if (sync_q == 1'b1) begin
          if (stab_cnt_q == c_stab_last) begin
            state_d    = IDLE_HIGH;
            stab_cnt_d = '0;
            level_d    = 1'b1;
            rise_d     = 1'b1;
          end else begin
            stab_cnt_d = stab_cnt_q + c_stab_one;
          end
        end
      end
      IDLE_HIGH: begin
        if (sync_q == 1'b0) begin
          state_d    = WAIT_LOW;
          stab_cnt_d = c_stab_one;
        end
      end
      WAIT_LOW: begin
        if (sync_q == 1'b1) begin
          state_d    = IDLE_HIGH;
          stab_cnt_d = '0;
        end else if (sync_q == 1'b0) begin
          if (stab_cnt_q == c_stab_last) begin
            state_d    = IDLE_LOW;
            stab_cnt_d = '0;
            level_d    = 1'b0;
            fall_d     = 1'b1;
          end else begin
            stab_cnt_d = stab_cnt_q + c_stab_one;
          end
        end
      end
      default: begin
        state_d    = IDLE_LOW;
        stab_cnt_d = '0;
      end
    endcase
  end

  // Rise counter: a clear wins over a coincident accepted rise.
  always_comb begin
    count_d = count_q;
    if (count_clr) begin
      count_d = '0;
    end else if (rise_d) begin
      count_d = count_q + c_cnt_one;
    end
  end

  // State, outputs and counter registers; reset overrides every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE_LOW;
      stab_cnt_q <= '0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      count_q    <= count_d;
    end
  end

  assign level       = level_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign event_count = count_q;

endmodule : input_debounce_edge
`default_nettype wire

// File: tb/tb_input_debounce_edge.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_debounce_edge
// Purpose  : Directed and randomised bench for input_debounce_edge with a
//            run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_debounce_edge;

  localparam int SC = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          d_in;
  logic          count_clr;
  logic          level;
  logic          rise;
  logic          fall;
  logic [CW-1:0] event_count;

  int total = 0;
  int bad   = 0;

  // Reference model: two-sample delay, then a value is accepted once it has
  // been seen for SC consecutive samples and differs from the current level.
  logic          m_p0, m_p1;
  logic          m_run_val;
  int            m_run_len;
  logic          m_level, m_rise, m_fall;
  logic [CW-1:0] m_cnt;

  input_debounce_edge #(
    .STABLE_CYCLES (SC),
    .CNT_W         (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .d_in        (d_in),
    .count_clr   (count_clr),
    .level       (level),
    .rise        (rise),
    .fall        (fall),
    .event_count (event_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic d, input logic clr, input logic rst);
    logic seen;
    if (rst) begin
      m_p0 = 1'b0; m_p1 = 1'b0;
      m_run_val = 1'b0; m_run_len = 0;
      m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
      m_cnt = '0;
    end else begin
      seen = m_p1;
      m_p1 = m_p0;
      m_p0 = d;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (seen == m_run_val) m_run_len++;
      else begin
        m_run_val = seen;
        m_run_len = 1;
      end
      if (m_run_val != m_level && m_run_len >= SC) begin
        m_level = m_run_val;
        m_rise  = m_run_val;
        m_fall  = ~m_run_val;
      end
      if (clr) m_cnt = '0;
      else if (m_rise) m_cnt = m_cnt + 1'b1;
    end
  endtask

  // Drive inputs, take one edge, update the model, then compare off the edge.
  task automatic tick(input logic d, input logic clr, input logic rst);
    d_in = d;
    count_clr = clr;
    reset = rst;
    @(posedge clk);
    model_edge(d, clr, rst);
    #1;
    check("model_level", CW'(level), CW'(m_level));
    check("model_rise",  CW'(rise),  CW'(m_rise));
    check("model_fall",  CW'(fall),  CW'(m_fall));
    check("model_count", event_count, m_cnt);
  endtask

  initial begin
    logic d;
    int   len;

    d_in = 1'b0; count_clr = 1'b0; reset = 1'b1;
    m_p0 = 1'b0; m_p1 = 1'b0; m_run_val = 1'b0; m_run_len = 0;
    m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_cnt = '0;

    // Reset, then quiet low input.
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("reset_count", event_count, 4'd0);
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      check("idle_level", CW'(level), 4'd0);
      check("idle_rise",  CW'(rise),  4'd0);
    end

    // Clean rise: accepted on edge 5 only.
    for (int k = 0; k < 7; k++) begin
      tick(1'b1, 1'b0, 1'b0);
      check("dir_rise",  CW'(rise),  CW'(k == 5));
      check("dir_level", CW'(level), CW'(k >= 5));
    end
    check("dir_rise_count", event_count, 4'd1);

    // Short low glitch is ignored.
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b0, 1'b0);
      check("glitch_level", CW'(level), 4'd1);
      check("glitch_fall",  CW'(fall),  4'd0);
    end
    check("glitch_count", event_count, 4'd1);

    // Clean fall: accepted on edge 5 only.
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      check("dir_fall",       CW'(fall),  CW'(k == 5));
      check("dir_fall_level", CW'(level), CW'(k < 5));
    end
    check("dir_fall_count", event_count, 4'd1);

    // Wraparound over 16 pulses, starting from a cleared counter.
    tick(1'b0, 1'b1, 1'b0);
    check("clr_count", event_count, 4'd0);
    for (int p = 1; p <= 16; p++) begin
      for (int k = 0; k < 8; k++) tick(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 1'b0);
      check("wrap_count", event_count, CW'(p % 16));
    end

    // Clear coincident with an accepted rise: clear wins, rise still fires.
    for (int k = 0; k < 7; k++) begin
      tick(1'b1, logic'(k == 5), 1'b0);
      if (k == 5) begin
        check("clr_rise_pulse", CW'(rise),  4'd1);
        check("clr_rise_count", event_count, 4'd0);
      end
    end
    check("clr_rise_level", CW'(level), 4'd1);

    // Reset during WAIT_HIGH aborts the transition; re-accepted later.
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 1'b0, logic'(k == 3));
      check("rst_mid_rise",  CW'(rise),  CW'(k == 9));
      check("rst_mid_level", CW'(level), CW'(k == 9));
    end
    check("rst_mid_count", event_count, 4'd1);

    // Randomised runs with occasional clears and resets.
    for (int i = 0; i < 250; i++) begin
      d   = logic'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) begin
        tick(d, logic'($urandom_range(0, 29) == 0), logic'($urandom_range(0, 79) == 0));
        check("rand_excl", CW'(rise & fall), 4'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_input_debounce_edge
`default_nettype wire
